// File: rtl/entropy_conditioner.sv
// Noise-bit conditioner: synchronises a raw asynchronous bit, whitens it with a von Neumann
// debiaser, flags stuck sources and buffers whitened bits in a small single-bit FIFO pool.
module entropy_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int POOL_BITS   = 16,
  parameter int REP_LIMIT   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             raw,
  input  logic                             sample_en,
  input  logic                             take,
  output logic                             entropy,
  output logic                             entropy_valid,
  output logic [$clog2(POOL_BITS+1)-1:0]   level,
  output logic                             stuck,
  output logic                             overrun
);

  localparam int LVL_W = $clog2(POOL_BITS + 1);
  localparam int PTR_W = $clog2(POOL_BITS);
  localparam logic [7:0]       REP_CAP  = 8'(REP_LIMIT);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(POOL_BITS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(POOL_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic [7:0]             rep_cnt_q;
  logic                   stuck_q;
  logic                   half_q;
  logic                   first_q;
  logic [POOL_BITS-1:0]   mem_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [LVL_W-1:0]       count_q;
  logic                   overrun_q;
  logic                   entropy_q;
  logic                   valid_q;

  logic s;
  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    push   = 1'b0;
    if (sample_en && half_q && (first_q != s) && !stuck_q)
      push = 1'b1;
    pop    = take && (count_q != '0);
    full   = (count_q == LVL_FULL);
    accept = push && (!full || pop);
    drop   = push && full && !pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      last_q    <= 1'b0;
      rep_cnt_q <= '0;
      stuck_q   <= 1'b0;
      half_q    <= 1'b0;
      first_q   <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      entropy_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      // stuck lags rep_cnt by one register stage, so the debiaser sees the pre-sample health state.
      stuck_q <= (rep_cnt_q >= REP_CAP);

      if (sample_en) begin
        last_q <= s;
        if ((rep_cnt_q == '0) || (s != last_q))
          rep_cnt_q <= 8'd1;
        else if (rep_cnt_q < REP_CAP)
          rep_cnt_q <= rep_cnt_q + 8'd1;

        if (!half_q) begin
          first_q <= s;
          half_q  <= 1'b1;
        end else begin
          half_q  <= 1'b0;
        end
      end

      if (accept) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= wrap_inc(rd_ptr_q);

      case ({accept, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase

      if (drop) overrun_q <= 1'b1;

      entropy_q <= pop ? mem_q[rd_ptr_q] : 1'b0;
      valid_q   <= pop;
    end
  end

  // NOTE: pool storage is not reset; the pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept && !rst)
      mem_q[wr_ptr_q] <= first_q;
  end

  assign entropy       = entropy_q;
  assign entropy_valid = valid_q;
  assign level         = count_q;
  assign stuck         = stuck_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_entropy_conditioner.sv
// Directed bench for entropy_conditioner: ordering, empty/full corner cases, stuck detection
// and mid-operation reset, each against hand-computed expectations.
module tb_entropy_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int POOL_BITS   = 16;
  localparam int REP_LIMIT   = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw;
  logic       sample_en;
  logic       take;
  logic       entropy;
  logic       entropy_valid;
  logic [4:0] level;
  logic       stuck;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  entropy_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .POOL_BITS  (POOL_BITS),
    .REP_LIMIT  (REP_LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw          (raw),
    .sample_en    (sample_en),
    .take         (take),
    .entropy      (entropy),
    .entropy_valid(entropy_valid),
    .level        (level),
    .stuck        (stuck),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one bit on raw, let it ripple through the synchroniser, then sample it.
  task automatic samp(input logic b, input logic tk);
    raw       = b;
    sample_en = 1'b0;
    take      = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) step();
    sample_en = 1'b1;
    take      = tk;
    step();
    sample_en = 1'b0;
    take      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_entropy"}, 32'(entropy), 32'd0);
    check({tag, "_valid"},   32'(entropy_valid), 32'd0);
    check({tag, "_level"},   32'(level), 32'd0);
    check({tag, "_stuck"},   32'(stuck), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_bits;
    rst = 1'b1; raw = 1'b0; sample_en = 1'b0; take = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // Ordering: pairs 10,01,10,10 -> whitened 1,0,1,1.
    samp(1, 0); samp(0, 0);
    samp(0, 0); samp(1, 0);
    samp(1, 0); samp(0, 0);
    samp(1, 0); samp(0, 0);
    check("order_level", 32'(level), 32'd4);
    exp_bits = 4'b1101;
    take = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("order_bit%0d", i), 32'(entropy), 32'(exp_bits[i]));
      check($sformatf("order_valid%0d", i), 32'(entropy_valid), 32'd1);
    end
    step();
    check("order_empty_entropy", 32'(entropy), 32'd0);
    check("order_empty_valid", 32'(entropy_valid), 32'd0);
    check("order_end_level", 32'(level), 32'd0);
    take = 1'b0;

    // Empty pool: push coincides with take, no bypass.
    samp(1, 0); samp(0, 1);
    check("emptypop_valid", 32'(entropy_valid), 32'd0);
    check("emptypop_level", 32'(level), 32'd1);
    take = 1'b1;
    step();
    take = 1'b0;
    check("emptypop_next_bit", 32'(entropy), 32'd1);
    check("emptypop_next_valid", 32'(entropy_valid), 32'd1);
    check("emptypop_next_level", 32'(level), 32'd0);

    // Alternating source fills the pool with zeros.
    for (int i = 0; i < POOL_BITS; i++) begin
      samp(0, 0); samp(1, 0);
    end
    check("alt_full_level", 32'(level), 32'd16);
    check("alt_full_overrun", 32'(overrun), 32'd0);
    check("alt_stuck", 32'(stuck), 32'd0);

    // Push of a 1 together with a pop at full: accepted, oldest (0) leaves.
    samp(1, 0); samp(0, 1);
    check("fullpp_level", 32'(level), 32'd16);
    check("fullpp_overrun", 32'(overrun), 32'd0);
    check("fullpp_entropy", 32'(entropy), 32'd0);
    check("fullpp_valid", 32'(entropy_valid), 32'd1);

    // Push at full without pop is dropped.
    samp(0, 0); samp(1, 0);
    check("overrun_level", 32'(level), 32'd16);
    check("overrun_flag", 32'(overrun), 32'd1);

    // Drain nine zeros: pool now holds six zeros then the accepted 1.
    take = 1'b1;
    for (int i = 0; i < 9; i++) step();
    take = 1'b0;
    check("drain_entropy", 32'(entropy), 32'd0);
    check("drain_level", 32'(level), 32'd7);
    check("drain_overrun_sticky", 32'(overrun), 32'd1);

    // Previous sample was 1, so the 31st further 1 makes 32 consecutive.
    for (int i = 0; i < 31; i++) samp(1, 0);
    check("stuck_pre_rise", 32'(stuck), 32'd0);
    step();
    check("stuck_rise", 32'(stuck), 32'd1);
    for (int i = 0; i < 9; i++) samp(1, 0);
    check("stuck_hold", 32'(stuck), 32'd1);
    check("stuck_level", 32'(level), 32'd7);

    // Mid-operation reset with level=7, overrun=1, stuck=1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    samp(1, 0); samp(0, 0);
    check("postrst_level", 32'(level), 32'd1);
    take = 1'b1;
    step();
    take = 1'b0;
    check("postrst_entropy", 32'(entropy), 32'd1);
    check("postrst_valid", 32'(entropy_valid), 32'd1);

    // Stuck from a fresh run of 1s (previous sample 0): rises after sample 32.
    for (int i = 0; i < 32; i++) samp(1, 0);
    check("stuck2_pre_rise", 32'(stuck), 32'd0);
    step();
    check("stuck2_rise", 32'(stuck), 32'd1);
    for (int i = 0; i < 2; i++) samp(1, 0);
    // Pair 10 while stuck: whitened 1 is discarded; the 0 sample clears stuck a cycle later.
    samp(1, 0); samp(0, 0);
    check("stuck2_discard_level", 32'(level), 32'd0);
    check("stuck2_still_set", 32'(stuck), 32'd1);
    step();
    check("stuck2_clear", 32'(stuck), 32'd0);
    samp(0, 0); samp(1, 0);
    check("recover_level", 32'(level), 32'd1);
    take = 1'b1;
    step();
    take = 1'b0;
    check("recover_entropy", 32'(entropy), 32'd0);
    check("recover_valid", 32'(entropy_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
